// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: GP operand forwarding scoreboard.
// Tracks in-flight write descriptors for NSTAGE result stages, forwards the
// youngest ready producer to each of NRD read ports, and stalls decode when
// a producer's result is not yet available (load-use hazard). A one-entry
// retire buffer covers the register-file write/read gap.
// Optional statistics counters are built when FORWARD_STATS_EN is defined;
// otherwise or_stall_cnt and or_fwd_cnt are tied to zero.
module fwd_scoreboard #(
  parameter int DATA_W = 24,
  parameter int IDX_W  = 4,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int LAT_W  = 2
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_hold,
  input  logic                     iw_flush,
  input  logic                     iw_issue_valid,
  input  logic                     iw_issue_we,
  input  logic [IDX_W-1:0]         iw_issue_tgt,
  input  logic [LAT_W-1:0]         iw_issue_lat,
  input  logic [NRD-1:0]           iw_rd_en,
  input  logic [NRD*IDX_W-1:0]     iw_rd_idx,
  input  logic [NRD*DATA_W-1:0]    iw_rf_data,
  input  logic [NSTAGE*DATA_W-1:0] iw_stage_result,
  output logic [NRD*DATA_W-1:0]    or_rd_val,
  output logic                     or_stall,
  output logic                     or_issue_ack,
  output logic [31:0]              or_stall_cnt,
  output logic [31:0]              or_fwd_cnt
);

  localparam logic [LAT_W:0]   NSTAGE_L = (LAT_W+1)'(NSTAGE);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(NSTAGE - 1);

  // Descriptor pipeline, stage 0 is the youngest
  logic [NSTAGE-1:0] v_q;
  logic [NSTAGE-1:0] we_q;
  logic [IDX_W-1:0]  tgt_q [NSTAGE];
  logic [LAT_W-1:0]  lat_q [NSTAGE];

  // Retire buffer holding the value that just left the last stage
  logic              rv_q;
  logic [IDX_W-1:0]  rtgt_q;
  logic [DATA_W-1:0] rval_q;

  logic [NRD-1:0]    port_found;
  logic [NRD-1:0]    port_pending;
  logic [NRD-1:0]    port_hit;
  logic [LAT_W-1:0]  issue_lat_c;

  // A latency beyond the last tracked stage means "valid at the last stage"
  assign issue_lat_c = ({1'b0, iw_issue_lat} >= NSTAGE_L) ? LAST_LAT : iw_issue_lat;

  // Per-port lookup: youngest matching stage wins, then retire buffer, then RF
  always_comb begin
    or_rd_val    = iw_rf_data;
    port_found   = '0;
    port_pending = '0;
    port_hit     = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int s = 0; s < NSTAGE; s++) begin
        if (!port_found[p] && v_q[s] && we_q[s] &&
            (tgt_q[s] == iw_rd_idx[p*IDX_W +: IDX_W])) begin
          port_found[p] = 1'b1;
          or_rd_val[p*DATA_W +: DATA_W] = iw_stage_result[s*DATA_W +: DATA_W];
          if (LAT_W'(s) < lat_q[s]) begin
            port_pending[p] = 1'b1;
          end else begin
            port_hit[p] = 1'b1;
          end
        end
      end
      if (!port_found[p] && rv_q && (rtgt_q == iw_rd_idx[p*IDX_W +: IDX_W])) begin
        or_rd_val[p*DATA_W +: DATA_W] = rval_q;
        port_hit[p] = 1'b1;
      end
    end
  end

  // Only enabled ports waiting on a not-yet-ready producer hold decode
  assign or_stall     = |(iw_rd_en & port_pending);
  assign or_issue_ack = iw_issue_valid & ~or_stall & ~iw_flush & ~iw_hold;

  // Advance descriptors and retire buffer unless the back end is held
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      v_q    <= '0;
      we_q   <= '0;
      for (int s = 0; s < NSTAGE; s++) begin
        tgt_q[s] <= '0;
        lat_q[s] <= '0;
      end
      rv_q   <= 1'b0;
      rtgt_q <= '0;
      rval_q <= '0;
    end else if (!iw_hold) begin
      v_q[0]   <= or_issue_ack;
      we_q[0]  <= iw_issue_we;
      tgt_q[0] <= iw_issue_tgt;
      lat_q[0] <= issue_lat_c;
      for (int s = 1; s < NSTAGE; s++) begin
        v_q[s]   <= v_q[s-1];
        we_q[s]  <= we_q[s-1];
        tgt_q[s] <= tgt_q[s-1];
        lat_q[s] <= lat_q[s-1];
      end
      rv_q   <= v_q[NSTAGE-1] & we_q[NSTAGE-1];
      rtgt_q <= tgt_q[NSTAGE-1];
      rval_q <= iw_stage_result[(NSTAGE-1)*DATA_W +: DATA_W];
    end
  end

`ifdef FORWARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  // Saturating stall and forward-hit statistics
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (!iw_hold && or_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((|(iw_rd_en & port_hit)) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign or_stall_cnt = stall_cnt_q;
  assign or_fwd_cnt   = fwd_cnt_q;
`else
  logic unused_hit;

  assign unused_hit   = ^port_hit;
  assign or_stall_cnt = 32'd0;
  assign or_fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based model of the in-flight instruction window.
module tb_fwd_scoreboard;

  localparam int DW = 24;
  localparam int IW = 4;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold, flush, issue_valid, issue_we;
  logic [IW-1:0]     issue_tgt;
  logic [LW-1:0]     issue_lat;
  logic [NR-1:0]     rd_en;
  logic [NR*IW-1:0]  rd_idx;
  logic [NR*DW-1:0]  rf_data;
  logic [NS*DW-1:0]  stage_result;
  logic [NR*DW-1:0]  rd_val;
  logic              stall, issue_ack;
  logic [31:0]       stall_cnt, fwd_cnt;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard #(.DATA_W(DW), .IDX_W(IW), .NSTAGE(NS), .NRD(NR), .LAT_W(LW)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_hold(hold), .iw_flush(flush),
    .iw_issue_valid(issue_valid), .iw_issue_we(issue_we),
    .iw_issue_tgt(issue_tgt), .iw_issue_lat(issue_lat),
    .iw_rd_en(rd_en), .iw_rd_idx(rd_idx), .iw_rf_data(rf_data),
    .iw_stage_result(stage_result), .or_rd_val(rd_val), .or_stall(stall),
    .or_issue_ack(issue_ack), .or_stall_cnt(stall_cnt), .or_fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  // Model: a window of the last NS issue slots, newest first, plus the
  // instruction that most recently fell out of the window.
  typedef struct {
    bit          v;
    bit          we;
    logic [IW-1:0] tgt;
    int          lat;
  } desc_t;

  desc_t         pipe[$];
  bit            ret_v;
  logic [IW-1:0] ret_tgt;
  logic [DW-1:0] ret_val;
  logic [31:0]   exp_stall_cnt;
  logic [31:0]   exp_fwd_cnt;

  function automatic void model_reset();
    desc_t e;
    e.v = 0; e.we = 0; e.tgt = '0; e.lat = 0;
    pipe.delete();
    for (int i = 0; i < NS; i++) pipe.push_back(e);
    ret_v = 0; ret_tgt = '0; ret_val = '0;
    exp_stall_cnt = '0; exp_fwd_cnt = '0;
  endfunction

  // Value a port should see: an instruction of age a produces at stage a,
  // and its value exists only once a has reached its latency.
  function automatic void model_port(input int p, output logic [DW-1:0] val,
                                     output bit pend, output bit hit);
    logic [IW-1:0] idx;
    idx  = rd_idx[p*IW +: IW];
    val  = rf_data[p*DW +: DW];
    pend = 0;
    hit  = 0;
    for (int a = 0; a < pipe.size(); a++) begin
      if (pipe[a].v && pipe[a].we && pipe[a].tgt == idx) begin
        if (a >= pipe[a].lat) begin
          val = stage_result[a*DW +: DW];
          hit = 1;
        end else begin
          pend = 1;
        end
        return;
      end
    end
    if (ret_v && ret_tgt == idx) begin
      val = ret_val;
      hit = 1;
    end
  endfunction

  function automatic bit model_stall();
    logic [DW-1:0] v;
    bit pd, ht, s;
    s = 0;
    for (int p = 0; p < NR; p++) begin
      model_port(p, v, pd, ht);
      if (rd_en[p] && pd) s = 1;
    end
    return s;
  endfunction

  function automatic bit model_ack();
    return issue_valid && !model_stall() && !flush && !hold;
  endfunction

  // One clock: model follows the edge with the inputs currently driven
  task automatic tick();
    logic [DW-1:0] v;
    bit pd, ht, any_hit, s, a;
    desc_t d, last;
    logic [DW-1:0] last_res;
    any_hit = 0;
    for (int p = 0; p < NR; p++) begin
      model_port(p, v, pd, ht);
      if (rd_en[p] && ht) any_hit = 1;
    end
    s = model_stall();
    a = model_ack();
    last_res = stage_result[(NS-1)*DW +: DW];
    @(posedge clk);
    if (!hold) begin
      d.v   = a;
      d.we  = issue_we;
      d.tgt = issue_tgt;
      d.lat = (int'(issue_lat) >= NS) ? NS - 1 : int'(issue_lat);
      last  = pipe[$];
      pipe.push_front(d);
      void'(pipe.pop_back());
      ret_v   = last.v && last.we;
      ret_tgt = last.tgt;
      ret_val = last_res;
      if (s && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt = exp_stall_cnt + 1;
    end
    if (any_hit && exp_fwd_cnt != 32'hFFFF_FFFF) exp_fwd_cnt = exp_fwd_cnt + 1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hold = 0; flush = 0; issue_valid = 0; issue_we = 0;
    issue_tgt = '0; issue_lat = '0; rd_en = '0; rd_idx = '0;
    for (int p = 0; p < NR; p++) rf_data[p*DW +: DW] = DW'($urandom);
    for (int s = 0; s < NS; s++) stage_result[s*DW +: DW] = DW'($urandom);
  endtask

  task automatic issue(input logic [IW-1:0] tgt, input logic [LW-1:0] lat);
    clear_inputs();
    issue_valid = 1; issue_we = 1; issue_tgt = tgt; issue_lat = lat;
  endtask

  task automatic drain();
    clear_inputs();
    for (int i = 0; i <= NS; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (issue_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", issue_ack); end
    checks++;
    if (rd_val !== rf_data) begin errors++; $display("[TB] FAIL reset_rdval: got %h expected %h", rd_val, rf_data); end
    checks++;
    if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %h/%h expected 0/0", stall_cnt, fwd_cnt);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_back_to_back();
    issue(4'd5, 2'd0);
    #1;
    checks++;
    if (issue_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack: got %b expected 1", issue_ack); end
    tick();
    clear_inputs();
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd5; stage_result[0 +: DW] = 24'h123456;
    #1;
    checks++;
    if (rd_val[0 +: DW] !== 24'h123456) begin errors++; $display("[TB] FAIL b2b_val: got %h expected 123456", rd_val[0 +: DW]); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall: got %b expected 0", stall); end
    drain();
  endtask

  task automatic test_load_use();
    issue(4'd3, 2'd1);
    tick();
    clear_inputs();
    issue_valid = 1; issue_we = 0;
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd3;
    #1;
    checks++;
    if (stall !== 1'b1 || issue_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL loaduse_stall: got stall=%b ack=%b expected stall=1 ack=0", stall, issue_ack);
    end
    tick();
    stage_result[1*DW +: DW] = 24'hABCDEF;
    #1;
    checks++;
    if (rd_val[0 +: DW] !== 24'hABCDEF) begin errors++; $display("[TB] FAIL loaduse_val: got %h expected abcdef", rd_val[0 +: DW]); end
    checks++;
    if (stall !== 1'b0 || issue_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL loaduse_release: got stall=%b ack=%b expected stall=0 ack=1", stall, issue_ack);
    end
    tick();
    drain();
  endtask

  task automatic test_priority();
    issue(4'd7, 2'd0); tick();
    issue(4'd1, 2'd0); tick();
    issue(4'd7, 2'd0); tick();
    clear_inputs();
    rd_en = 2'b11; rd_idx[0 +: IW] = 4'd7; rd_idx[IW +: IW] = 4'd7;
    stage_result[0 +: DW] = 24'h000111;
    stage_result[DW +: DW] = 24'h999999;
    stage_result[2*DW +: DW] = 24'h000222;
    #1;
    checks++;
    if (rd_val !== {24'h000111, 24'h000111}) begin
      errors++; $display("[TB] FAIL prio_val: got %h expected 000111000111", rd_val);
    end
    drain();
    issue(4'd9, 2'd2); tick();
    clear_inputs();
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd0; rd_idx[IW +: IW] = 4'd9;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL prio_disabled_nostall: got %b expected 0", stall); end
    rd_en = 2'b11;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL prio_enabled_stall: got %b expected 1", stall); end
    drain();
  endtask

  task automatic test_retire();
    issue(4'd2, 2'd0); tick();
    clear_inputs();
    tick(); tick();
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd2;
    stage_result[2*DW +: DW] = 24'h0000AA;
    #1;
    checks++;
    if (rd_val[0 +: DW] !== 24'h0000AA) begin errors++; $display("[TB] FAIL retire_stage: got %h expected 0000aa", rd_val[0 +: DW]); end
    tick();
    stage_result[2*DW +: DW] = 24'h555555;
    rf_data[0 +: DW] = 24'h000000;
    #1;
    checks++;
    if (rd_val[0 +: DW] !== 24'h0000AA) begin errors++; $display("[TB] FAIL retire_buf: got %h expected 0000aa", rd_val[0 +: DW]); end
    tick();
    #1;
    checks++;
    if (rd_val[0 +: DW] !== 24'h000000) begin errors++; $display("[TB] FAIL retire_expire: got %h expected 000000", rd_val[0 +: DW]); end
    drain();
  endtask

  task automatic test_hold_flush();
    issue(4'd4, 2'd0); tick();
    clear_inputs();
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd4;
    stage_result[0 +: DW] = 24'h0BEEF0;
    hold = 1; issue_valid = 1; issue_we = 1; issue_tgt = 4'd8;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rd_val[0 +: DW] !== 24'h0BEEF0 || issue_ack !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_frozen[%0d]: got val=%h ack=%b expected val=0beef0 ack=0", c, rd_val[0 +: DW], issue_ack);
      end
      if (c < 2) tick();
    end
    hold = 0; flush = 1; issue_tgt = 4'd6;
    #1;
    checks++;
    if (issue_ack !== 1'b0) begin errors++; $display("[TB] FAIL flush_ack: got %b expected 0", issue_ack); end
    tick();
    flush = 0; issue_valid = 0;
    rd_en = 2'b11; rd_idx[0 +: IW] = 4'd6; rd_idx[IW +: IW] = 4'd4;
    rf_data[0 +: DW] = 24'h000666;
    stage_result[0 +: DW] = 24'h777777;
    stage_result[DW +: DW] = 24'h0C0FFE;
    #1;
    checks++;
    if (rd_val !== {24'h0C0FFE, 24'h000666}) begin
      errors++; $display("[TB] FAIL flush_bubble: got %h expected 0c0ffe000666", rd_val);
    end
    drain();
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    bit pd, ht, s, a;
    for (int n = 0; n < 600; n++) begin
      hold        = ($urandom_range(7) == 0);
      flush       = ($urandom_range(7) == 0);
      issue_valid = ($urandom_range(3) != 0);
      issue_we    = ($urandom_range(3) != 0);
      issue_tgt   = IW'($urandom_range(3));
      issue_lat   = LW'($urandom_range(3));
      rd_en       = NR'($urandom);
      for (int p = 0; p < NR; p++) begin
        rd_idx[p*IW +: IW]  = IW'($urandom_range(3));
        rf_data[p*DW +: DW] = DW'($urandom);
      end
      for (int st = 0; st < NS; st++) stage_result[st*DW +: DW] = DW'($urandom);
      #1;
      s = model_stall();
      a = model_ack();
      checks++;
      if (stall !== s) begin errors++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, stall, s); end
      checks++;
      if (issue_ack !== a) begin errors++; $display("[TB] FAIL rand_ack[%0d]: got %b expected %b", n, issue_ack, a); end
      for (int p = 0; p < NR; p++) begin
        model_port(p, v, pd, ht);
        if (!pd) begin
          checks++;
          if (rd_val[p*DW +: DW] !== v) begin
            errors++; $display("[TB] FAIL rand_val[%0d] port %0d: got %h expected %h", n, p, rd_val[p*DW +: DW], v);
          end
        end
      end
`ifdef FORWARD_STATS_EN
      checks++;
      if (stall_cnt !== exp_stall_cnt || fwd_cnt !== exp_fwd_cnt) begin
        errors++; $display("[TB] FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, stall_cnt, fwd_cnt, exp_stall_cnt, exp_fwd_cnt);
      end
`endif
      tick();
    end
    drain();
  endtask

  task automatic test_async_reset();
    issue(4'd1, 2'd2); tick();
    issue(4'd2, 2'd2); tick();
    issue(4'd3, 2'd2); tick();
    clear_inputs();
    rd_en = 2'b01; rd_idx[0 +: IW] = 4'd3;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_stall: got %b expected 1", stall); end
    #1;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL areset_stall: got %b expected 0", stall); end
    checks++;
    if (rd_val !== rf_data) begin errors++; $display("[TB] FAIL areset_rdval: got %h expected %h", rd_val, rf_data); end
    checks++;
    if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL areset_cnt: got %h/%h expected 0/0", stall_cnt, fwd_cnt);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL areset_after: got %b expected 0", stall); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_retire();
    test_hold_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
